// File: rtl/kim_panel_emulator.sv
// Device-side emulation of the KIM-1 LED/keypad interface.
// Captures the multiplexed 6-digit display into a stable frame and answers
// keypad row scans for one host-injected key at a time.
//
// Keypad FSM:
//   state | meaning
//   IDLE  | ready for a key; columns released
//   PRESS | key held; the latched column follows its synced row select
//   GAP   | release gap before the next key; columns released
module kim_panel_emulator #(
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 65535,
    parameter int KEY_HOLD    = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  led_dig,
    input  logic [6:0]  led_seg,
    input  logic [3:0]  kb_row,
    output logic [6:0]  kb_col,
    input  logic        key_valid,
    input  logic [1:0]  key_row,
    input  logic [2:0]  key_col,
    output logic        key_ready,
    output logic [41:0] seg_frame,
    output logic [5:0]  digit_fresh,
    output logic        frame_strobe
);

    localparam int SW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int KW = (KEY_HOLD > 1) ? $clog2(KEY_HOLD) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] AGE_MAX  = TW'(TIMEOUT);
    localparam logic [KW-1:0] CNT_LOAD = KW'(KEY_HOLD - 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    logic [5:0] dig_s1_q, dig_s2_q;
    logic [6:0] seg_s1_q, seg_s2_q;
    logic [3:0] row_s1_q, row_s2_q;

    logic            cand;
    logic [2:0]      cand_idx;
    logic [2:0]      zero_cnt;
    logic            match;
    logic            fire;
    logic            prev_cand_q;
    logic [2:0]      prev_idx_q;
    logic [6:0]      prev_seg_q;
    logic [SW-1:0]   stab_q, stab_d;
    logic            done_q, done_d;

    logic [5:0][6:0]    frame_q, frame_d;
    logic [5:0]         fresh_q, fresh_d;
    logic [5:0][TW-1:0] age_q, age_d;
    logic [TW-1:0]      age_inc;
    logic               strobe_q, strobe_d;

    state_t        state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic [6:0]    kb_col_q, kb_col_d;
    logic [7:0]    col_onehot;

    // Two-flop synchronizers; preset high so nothing looks selected after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_s1_q <= '1;
            dig_s2_q <= '1;
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            row_s1_q <= '1;
            row_s2_q <= '1;
        end else begin
            dig_s1_q <= led_dig;
            dig_s2_q <= dig_s1_q;
            seg_s1_q <= led_seg;
            seg_s2_q <= seg_s1_q;
            row_s1_q <= kb_row;
            row_s2_q <= row_s1_q;
        end
    end

    // Candidate digit decode and stability run tracking; capture fires once per run.
    always_comb begin
        zero_cnt = '0;
        cand_idx = '0;
        for (int i = 0; i < 6; i++) begin
            if (!dig_s2_q[i]) begin
                zero_cnt = zero_cnt + 3'd1;
                cand_idx = 3'(i);
            end
        end
        cand   = (zero_cnt == 3'd1);
        match  = cand && prev_cand_q && (cand_idx == prev_idx_q) && (seg_s2_q == prev_seg_q);
        stab_d = '0;
        if (match) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
        end
        fire   = cand && (stab_d == STAB_MAX) && !(match && done_q);
        done_d = fire || (match && done_q);
    end

    // Per-digit capture and ageing; a capture beats a timeout in the same cycle.
    always_comb begin
        frame_d  = frame_q;
        fresh_d  = fresh_q;
        age_d    = age_q;
        age_inc  = '0;
        strobe_d = fire && (cand_idx == 3'd5);
        for (int d = 0; d < 6; d++) begin
            age_inc = (age_q[d] == AGE_MAX) ? age_q[d] : age_q[d] + TW'(1);
            if (fire && (cand_idx == 3'(d))) begin
                frame_d[d] = ~seg_s2_q;
                fresh_d[d] = 1'b1;
                age_d[d]   = '0;
            end else begin
                age_d[d] = age_inc;
                if (age_inc == AGE_MAX) begin
                    frame_d[d] = '0;
                    fresh_d[d] = 1'b0;
                end
            end
        end
    end

    // Display capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_cand_q <= 1'b0;
            prev_idx_q  <= '0;
            prev_seg_q  <= '0;
            stab_q      <= '0;
            done_q      <= 1'b0;
            frame_q     <= '0;
            fresh_q     <= '0;
            age_q       <= '0;
            strobe_q    <= 1'b0;
        end else begin
            prev_cand_q <= cand;
            prev_idx_q  <= cand_idx;
            prev_seg_q  <= seg_s2_q;
            stab_q      <= stab_d;
            done_q      <= done_d;
            frame_q     <= frame_d;
            fresh_q     <= fresh_d;
            age_q       <= age_d;
            strobe_q    <= strobe_d;
        end
    end

    // Keypad FSM next state; column 7 shifts out of the 7-bit mask as a dummy press.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        kb_col_d   = 7'h7F;
        key_ready  = (state_q == IDLE);
        col_onehot = 8'd1 << col_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    row_d   = key_row;
                    col_d   = key_col;
                    cnt_d   = CNT_LOAD;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_LOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - KW'(1);
                    if (!row_s2_q[row_q]) begin
                        kb_col_d = ~col_onehot[6:0];
                    end
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Keypad FSM registers; reset releases the columns at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            kb_col_q <= 7'h7F;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            kb_col_q <= kb_col_d;
        end
    end

    assign kb_col       = kb_col_q;
    assign seg_frame    = frame_q;
    assign digit_fresh  = fresh_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_kim_panel_emulator.sv
// Bench for kim_panel_emulator: directed scenarios plus a randomized run,
// every cycle compared against a timestamp-based behavioural model.
module tb_kim_panel_emulator;

    localparam int HOLD = 16;
    localparam int TMO  = 100;
    localparam int KH   = 50;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  dig;
    logic [6:0]  seg;
    logic [3:0]  krow;
    logic [6:0]  kb_col;
    logic        kv;
    logic [1:0]  kr;
    logic [2:0]  kc;
    logic        key_ready;
    logic [41:0] seg_frame;
    logic [5:0]  digit_fresh;
    logic        frame_strobe;

    always #5 clk = ~clk;

    kim_panel_emulator #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .KEY_HOLD(KH)) dut (
        .clk(clk), .reset_n(reset_n), .led_dig(dig), .led_seg(seg), .kb_row(krow),
        .kb_col(kb_col), .key_valid(kv), .key_row(kr), .key_col(kc),
        .key_ready(key_ready), .seg_frame(seg_frame), .digit_fresh(digit_fresh),
        .frame_strobe(frame_strobe)
    );

    // Reference model: synced copies of the pins, run length of the current
    // candidate, and the edge number at which each digit / key was taken.
    int         cyc;
    logic [5:0] md1, md2;
    logic [6:0] ms1, ms2;
    logic [3:0] mr1, mr2;
    int         run, run_idx;
    logic [6:0] run_seg;
    logic [6:0] m_val [6];
    int         m_last [6];
    logic       m_strobe;
    int         acc;
    logic [1:0] a_row;
    logic [2:0] a_col;
    logic [6:0] m_kb;
    int         n_cmp, n_bad;

    function automatic bit m_ready();
        return (acc < 0) || (cyc >= acc + 2 * KH);
    endfunction

    task automatic model_reset();
        md1 = '1; md2 = '1; ms1 = '1; ms2 = '1; mr1 = '1; mr2 = '1;
        run = 0; run_idx = 0; run_seg = '0;
        for (int d = 0; d < 6; d++) begin
            m_val[d] = '0;
            m_last[d] = -1;
        end
        m_strobe = 1'b0;
        acc = -1; a_row = '0; a_col = '0;
        m_kb = 7'h7F;
    endtask

    task automatic model_edge();
        int zeros, idx;
        bit rdy_prev;
        rdy_prev = m_ready();
        cyc++;
        zeros = 0; idx = 0;
        for (int i = 0; i < 6; i++) if (!md2[i]) begin zeros++; idx = i; end
        if (zeros == 1) begin
            if (run > 0 && idx == run_idx && ms2 == run_seg) run++;
            else begin run = 1; run_idx = idx; run_seg = ms2; end
        end else run = 0;
        m_strobe = 1'b0;
        if (run == HOLD) begin
            m_val[idx] = ~ms2;
            m_last[idx] = cyc;
            m_strobe = (idx == 5);
        end
        m_kb = 7'h7F;
        if (acc >= 0 && cyc > acc && cyc < acc + KH && a_col != 3'd7 && !mr2[a_row])
            m_kb = 7'h7F ^ 7'(1 << a_col);
        if (rdy_prev && kv) begin acc = cyc; a_row = kr; a_col = kc; end
        md2 = md1; md1 = dig;
        ms2 = ms1; ms1 = seg;
        mr2 = mr1; mr1 = krow;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [41:0] ef;
        logic [5:0]  efr;
        ef = '0; efr = '0;
        for (int d = 0; d < 6; d++) begin
            efr[d] = (m_last[d] >= 0) && (cyc - m_last[d] < TMO);
            ef[7*d +: 7] = efr[d] ? m_val[d] : 7'h00;
        end
        chk("seg_frame", 64'(seg_frame), 64'(ef));
        chk("digit_fresh", 64'(digit_fresh), 64'(efr));
        chk("frame_strobe", 64'(frame_strobe), 64'(m_strobe));
        chk("kb_col", 64'(kb_col), 64'(m_kb));
        chk("key_ready", 64'(key_ready), 64'(m_ready()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [41:0] exp_frame;
        logic [41:0] mask;
        int strobes, hits, exp_hits, busy, dwell, r;

        n_cmp = 0; n_bad = 0; cyc = 0;
        reset_n = 1'b0; dig = '1; seg = '1; krow = '1; kv = 1'b0; kr = '0; kc = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // T1: single digit 0 showing segment G; capture exactly at edge 2+HOLD.
        dig = 6'b111110; seg = 7'b1000000;
        repeat (HOLD + 1) step();
        chk("t1_not_yet", 64'(digit_fresh[0]), 64'd0);
        step();
        chk("t1_captured", 64'(digit_fresh[0]), 64'd1);
        repeat (2) step();
        chk("t1_seg0", 64'(seg_frame[6:0]), 64'h3F);

        // T2: two digits low, then toggling segments: no capture.
        dig = 6'b111100; seg = 7'h00;
        repeat (30) step();
        dig = 6'b111101;
        for (int k = 0; k < 5; k++) begin
            seg = k[0] ? 7'h55 : 7'h2A;
            repeat (8) step();
        end
        chk("t2_fresh1", 64'(digit_fresh[1]), 64'd0);
        chk("t2_seg1", 64'(seg_frame[13:7]), 64'd0);

        // T3: full frame, digit d shows code d, three passes.
        strobes = 0;
        exp_frame = '0;
        for (int p = 0; p < 3; p++) begin
            for (int d = 0; d < 6; d++) begin
                dig = ~6'(1 << d); seg = ~7'(d);
                exp_frame[7*d +: 7] = 7'(d);
                repeat (HOLD) begin step(); if (frame_strobe) strobes++; end
            end
        end
        dig = '1; seg = '1;
        repeat (4) begin step(); if (frame_strobe) strobes++; end
        chk("t3_strobes", 64'(strobes), 64'd3);
        chk("t3_fresh", 64'(digit_fresh), 64'h3F);
        chk("t3_frame", 64'(seg_frame), 64'(exp_frame));

        // T4: stop scanning digit 3; it times out, the rest stay intact.
        for (int p = 0; p < 3; p++) begin
            for (int d = 0; d < 6; d++) begin
                if (d != 3) begin
                    dig = ~6'(1 << d); seg = ~7'(d);
                    repeat (HOLD) step();
                end
            end
        end
        mask = '1; mask[27:21] = '0;
        chk("t4_seg3", 64'(seg_frame[27:21]), 64'd0);
        chk("t4_fresh", 64'(digit_fresh), 64'h37);
        chk("t4_others", 64'(seg_frame & mask), 64'(exp_frame & mask));
        dig = '1; seg = '1;

        // T5: key row 2 col 4 against a rotating row scan.
        kv = 1'b1; kr = 2'd2; kc = 3'd4;
        hits = 0; exp_hits = 0; busy = 0;
        for (int i = 0; i < 2 * KH + 20; i++) begin
            krow = ~4'(1 << ((i / 2) % 4));
            step();
            if (kv && acc == cyc) kv = 1'b0;
            if (kb_col == 7'h6F) hits++;
            if (m_kb == 7'h6F) exp_hits++;
            if (!key_ready) busy++;
        end
        chk("t5_hits", 64'(hits), 64'(exp_hits));
        chk("t5_busy", 64'(busy), 64'(2 * KH));

        // T6: reset in the middle of a press.
        kv = 1'b1; kr = 2'd1; kc = 3'd0; krow = 4'b1101;
        repeat (10) begin step(); if (kv && acc == cyc) kv = 1'b0; end
        chk("t6_pressed", 64'(kb_col), 64'h7E);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_col_rst", 64'(kb_col), 64'h7F);
        chk("t6_rdy_rst", 64'(key_ready), 64'd1);
        model_reset();
        kv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
        kv = 1'b1; kr = 2'd3; kc = 3'd6;
        busy = 0;
        for (int i = 0; i < 2 * KH + 10; i++) begin
            krow = ~4'(1 << (i % 4));
            step();
            if (kv && acc == cyc) kv = 1'b0;
            if (!key_ready) busy++;
        end
        chk("t6_busy_after", 64'(busy), 64'(2 * KH));

        // Randomized display scanning, row scanning and key offers.
        dwell = 0;
        for (int i = 0; i < 1500; i++) begin
            if (dwell == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 7) dig = ~6'(1 << $urandom_range(0, 5));
                else if (r < 9) dig = 6'($urandom);
                else dig = '1;
                seg = 7'($urandom);
                dwell = int'($urandom_range(1, 30));
            end
            dwell--;
            if ($urandom_range(0, 1) == 0) krow = ~4'(1 << $urandom_range(0, 3));
            else krow = 4'($urandom);
            if (!kv && $urandom_range(0, 7) == 0) begin
                kv = 1'b1; kr = 2'($urandom); kc = 3'($urandom);
            end
            step();
            if (kv && acc == cyc) kv = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
